// File: rtl/mem_responder.sv
// Memory-side responder for the SLC3 CPU: word RAM behind a strobe/ready handshake.
// Define MEMIO_HEX_EN to map 0xFFFF to the switches (read) and the hex display (write).
module mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] DATA_W,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] SW,
    output logic [15:0] MDR_In,
    output logic        R,
    output logic [15:0] HEX_OUT
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StDone, StHold} state_e;

    state_e        state_q;
    logic [15:0]   addr_q;
    logic [15:0]   data_q;
    logic          wr_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   mdr_q;
    logic          r_q;

    logic [15:0] mem [DEPTH];

    logic        req;
    logic [15:0] cur_addr;
    logic        in_range;
    logic        ram_we;
    logic [15:0] rd_data;
`ifdef MEMIO_HEX_EN
    logic        io_hit;
    logic [15:0] hex_q;
`else
    logic        unused_sw;
`endif

    // In IDLE the live address is used so a zero-wait read can load MDR on the capture edge.
    always_comb begin
        req      = ~Mem_OE | ~Mem_WE;
        cur_addr = (state_q == StIdle) ? ADDR : addr_q;
        in_range = 32'(cur_addr) < DEPTH;
        rd_data  = '0;
        if (in_range) begin
            rd_data = mem[cur_addr[AW-1:0]];
        end
`ifdef MEMIO_HEX_EN
        io_hit = (cur_addr == 16'hFFFF);
        if (io_hit) begin
            rd_data = SW;
        end
        ram_we = (state_q == StDone) && wr_q && in_range && !io_hit;
`else
        ram_we = (state_q == StDone) && wr_q && in_range;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            mdr_q   <= '0;
            r_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            r_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q <= ADDR;
                        data_q <= DATA_W;
                        // Both strobes low counts as a write.
                        wr_q   <= ~Mem_WE;
                        cnt_q  <= CW'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state_q <= StDone;
                            r_q     <= 1'b1;
                            if (Mem_WE) begin
                                mdr_q <= rd_data;
                            end
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= StDone;
                        r_q     <= 1'b1;
                        if (!wr_q) begin
                            mdr_q <= rd_data;
                        end
                    end
                end
                StDone: state_q <= StHold;
                StHold: begin
                    if (!req) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Write lands on the edge leaving DONE; a reset on that edge abandons it.
    always_ff @(posedge Clk) begin
        if (!Reset && ram_we) begin
            mem[addr_q[AW-1:0]] <= data_q;
        end
    end

`ifdef MEMIO_HEX_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hex_q <= '0;
        end else if (state_q == StDone && wr_q && io_hit) begin
            hex_q <= data_q;
        end
    end
    assign HEX_OUT = hex_q;
`else
    assign unused_sw = ^SW;
    assign HEX_OUT   = '0;
`endif

    assign MDR_In = mdr_q;
    assign R      = r_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (2 and 0 wait states) share one stimulus
// stream; a behavioural memory model predicts each ready pulse's timing and read data.
module tb_mem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WMAX  = 2;

    logic        Clk    = 1'b0;
    logic        Reset  = 1'b1;
    logic [15:0] ADDR   = '0;
    logic [15:0] DATA_W = '0;
    logic [15:0] SW     = '0;
    logic        Mem_OE = 1'b1;
    logic        Mem_WE = 1'b1;

    logic [1:0]       r_v;
    logic [1:0][15:0] mdr_v;
    logic [1:0][15:0] hex_v;

    // Index 0: WAIT_CYCLES=2, index 1: WAIT_CYCLES=0.
    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .DATA_W(DATA_W), .Mem_OE(Mem_OE),
        .Mem_WE(Mem_WE), .SW(SW), .MDR_In(mdr_v[0]), .R(r_v[0]), .HEX_OUT(hex_v[0])
    );
    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .DATA_W(DATA_W), .Mem_OE(Mem_OE),
        .Mem_WE(Mem_WE), .SW(SW), .MDR_In(mdr_v[1]), .R(r_v[1]), .HEX_OUT(hex_v[1])
    );

    typedef struct packed {
        int unsigned due;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    exp_t        expq [2][$];
    logic [15:0] mm [2][DEPTH];
    bit          vld [DEPTH];
    logic [15:0] hexm [2];
    logic [15:0] last_rd [2];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic        rst_s = 1'b1;
    bit          mon_en = 1'b0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        cyc   <= cyc + 1;
        rst_s <= Reset;
    end

    function automatic int unsigned lat(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_rd(input int d, input logic [15:0] a);
        if (32'(a) < DEPTH) return mm[d][a];
`ifdef MEMIO_HEX_EN
        if (a == 16'hFFFF) return SW;
`endif
        return 16'h0000;
    endfunction

    task automatic model_wr(input int d, input logic [15:0] a, input logic [15:0] v);
        if (32'(a) < DEPTH) begin
            mm[d][a] = v;
            vld[a]   = 1'b1;
        end
`ifdef MEMIO_HEX_EN
        else if (a == 16'hFFFF) hexm[d] = v;
`endif
    endtask

    // One full handshake on both instances; ADDR/DATA_W are scrambled once captured.
    task automatic do_access(input logic [15:0] a, input logic [15:0] wd, input logic oe_n,
                             input logic we_n, input int hold);
        exp_t e;
        @(negedge Clk);
        ADDR   = a;
        DATA_W = wd;
        Mem_OE = oe_n;
        Mem_WE = we_n;
        for (int d = 0; d < 2; d++) begin
            e.due = cyc + 1 + lat(d);
            if (!we_n) begin
                model_wr(d, a, wd);
                e.rd   = 1'b0;
                e.data = '0;
            end else begin
                e.rd   = 1'b1;
                e.data = model_rd(d, a);
            end
            expq[d].push_back(e);
        end
        repeat (WMAX + 1 + hold) begin
            @(negedge Clk);
            ADDR   = 16'($urandom);
            DATA_W = 16'($urandom);
        end
        Mem_OE = 1'b1;
        Mem_WE = 1'b1;
        repeat (2) @(negedge Clk);
        for (int d = 0; d < 2; d++) chk($sformatf("dut%0d_hex_out", d), hex_v[d], hexm[d]);
    endtask

    // Monitor: every ready pulse must match the oldest expectation; MDR_In holds between reads.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                for (int d = 0; d < 2; d++) begin
                    if (rst_s) last_rd[d] = '0;
                    if (r_v[d] === 1'b1) begin
                        chk($sformatf("dut%0d_r_expected", d), 32'(expq[d].size() != 0), 1);
                        if (expq[d].size() != 0) begin
                            e = expq[d].pop_front();
                            chk($sformatf("dut%0d_r_latency", d), cyc, e.due);
                            if (e.rd) last_rd[d] = e.data;
                        end
                    end
                    chk($sformatf("dut%0d_mdr_in", d), mdr_v[d], last_rd[d]);
                end
            end
        end
    end

    initial begin
        int unsigned c;
        int unsigned k;
        int unsigned op;
        logic [15:0] a;
        hexm[0]    = '0;
        hexm[1]    = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;

        repeat (3) @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_reset_r", d), r_v[d], 0);
            chk($sformatf("dut%0d_reset_mdr", d), mdr_v[d], 0);
            chk($sformatf("dut%0d_reset_hex", d), hex_v[d], 0);
        end
        Reset  = 1'b0;
        mon_en = 1'b1;

        do_access(16'h0000, 16'hA5A5, 1'b1, 1'b0, 0);
        do_access(16'h0010, 16'h0C0C, 1'b1, 1'b0, 0);
        do_access(16'h0005, 16'h1234, 1'b1, 1'b0, 0);
        do_access(16'h0005, 16'h0000, 1'b0, 1'b1, 0);
        do_access(16'h0005, 16'h0000, 1'b0, 1'b1, 10);
        do_access(16'h0005, 16'h0000, 1'b0, 1'b1, 0);
        do_access(16'h0400, 16'hFFFF, 1'b1, 1'b0, 0);
        do_access(16'h0000, 16'h0000, 1'b0, 1'b1, 0);
        do_access(16'h0400, 16'h0000, 1'b0, 1'b1, 0);
        SW = 16'h00A5;
        do_access(16'hFFFF, 16'hBEEF, 1'b1, 1'b0, 0);
        do_access(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
        do_access(16'h03FF, 16'h55AA, 1'b0, 1'b0, 1);
        do_access(16'h03FF, 16'h0000, 1'b0, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 5) a = 16'($urandom_range(0, DEPTH - 1));
            else if (k <= 7) a = 16'($urandom_range(DEPTH, 16'hFFFE));
            else if (k == 8) a = 16'hFFFF;
            else a = (i % 2 == 0) ? 16'h0005 : 16'(DEPTH - 1);
            op = $urandom_range(0, 2);
            if (op == 0 && 32'(a) < DEPTH && !vld[a]) op = 1;
            SW = 16'($urandom);
            do_access(a, 16'($urandom), (op == 1), (op == 0), int'($urandom_range(0, 3)));
        end

        // Reset during WAIT of the 2-wait instance; the 0-wait instance has already written.
        @(negedge Clk);
        ADDR   = 16'h0010;
        DATA_W = 16'h7777;
        Mem_OE = 1'b1;
        Mem_WE = 1'b0;
        c = cyc;
        expq[1].push_back('{due: c + 1, rd: 1'b0, data: 16'h0000});
        model_wr(1, 16'h0010, 16'h7777);
        @(negedge Clk);
        ADDR = 16'($urandom);
        @(negedge Clk);
        Reset  = 1'b1;
        Mem_WE = 1'b1;
        @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_midreset_r", d), r_v[d], 0);
            chk($sformatf("dut%0d_midreset_mdr", d), mdr_v[d], 0);
            chk($sformatf("dut%0d_midreset_hex", d), hex_v[d], 0);
            hexm[d] = '0;
        end
        Reset = 1'b0;
        do_access(16'h0010, 16'h0000, 1'b0, 1'b1, 0);
        do_access(16'h0005, 16'h0000, 1'b0, 1'b1, 0);

        repeat (4) @(negedge Clk);
        for (int d = 0; d < 2; d++) chk($sformatf("dut%0d_pending", d), expq[d].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the SLC3 CPU's memory interface.
- Accepts read and write strobes with an address and write data from the CPU. Serves them from an internal word-addressed RAM after a programmable number of wait states.
- Returns read data on MDR_In with a one-cycle ready pulse.
- Optionally decodes memory-mapped I/O at 0xFFFF: switches on read, hex display register on write.
- Sits between the CPU's MAR/MDR/MIO_EN path and the board I/O.

Parameters:
- DEPTH, 1024, number of 16-bit RAM words. Valid addresses are 0..DEPTH-1.
- WAIT_CYCLES, 2, wait states inserted between strobe capture and ready. 0 is legal.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ADDR  in  16  word address, driven from MAR.
- DATA_W  in  16  write data, driven from MDR.
- Mem_OE  in  1  active-low read strobe.
- Mem_WE  in  1  active-low write strobe.
- SW  in  16  board switch inputs.
- MDR_In  out  16  registered read data to the CPU.
- R  out  1  ready; one-cycle pulse when an access completes.
- HEX_OUT  out  16  hex display register.

Behaviour:
- Reset (synchronous, active-high, on the Clk rising edge):
  - state=IDLE; MDR_In=0x0000; R=0; HEX_OUT=0x0000; wait counter=0.
  - RAM contents are not cleared.
- Reset asserted mid-access: the access is abandoned. No RAM write occurs unless the write edge has already passed. Next cycle state=IDLE.
- State machine IDLE -> WAIT -> DONE -> HOLD -> IDLE.
- IDLE:
  - Sample the strobes each cycle. A request is Mem_OE==0 or Mem_WE==0.
  - On a request: capture ADDR, DATA_W and the op in internal registers, load counter=WAIT_CYCLES.
  - Go to WAIT, or straight to DONE if WAIT_CYCLES==0.
  - Both strobes low at once: treated as a write. The read is ignored.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, next state is DONE.
  - ADDR/DATA_W changes during WAIT are ignored; captured values are used.
- DONE (exactly one cycle):
  - R=1.
  - Read: MDR_In loads RAM[captured addr] at the edge entering DONE, so it is valid while R=1.
  - Write: RAM[captured addr] or HEX_OUT is updated on the edge leaving DONE. MDR_In is unchanged.
  - Next state is HOLD.
- HOLD:
  - R=0.
  - Wait until Mem_OE==1 and Mem_WE==1, then go to IDLE.
  - A held strobe never triggers a second access.
- Latency: R is asserted exactly WAIT_CYCLES+1 cycles after the IDLE cycle that sampled the strobe.
- MDR_In holds the last read value until the next read completes.
- Out-of-range address (>= DEPTH, and not the decoded I/O address): reads return 0x0000, writes are dropped. Still a normal ready handshake.
- Only ADDR bits needed for DEPTH index the RAM. No wrap-around aliasing; the range check uses all 16 bits.
- R is never high in two consecutive cycles.

Optional Feature:
- Macro: MEMIO_HEX_EN.
- Defined:
  - Address 0xFFFF is memory-mapped I/O.
  - A read returns the value of SW sampled at the edge entering DONE.
  - A write loads HEX_OUT with the captured DATA_W.
  - RAM is not touched.
- Not defined:
  - 0xFFFF is an ordinary out-of-range address (read 0x0000, write dropped).
  - HEX_OUT is tied to 0x0000.
  - The SW input is unused.

Test Plan:
- WAIT_CYCLES=2. Write 0x1234 to addr 0x0005 (Mem_WE low), release the strobe after R, then read 0x0005.
  -> R pulses 3 cycles after each sample; MDR_In=0x1234 during the read's R cycle.
- WAIT_CYCLES=0. Read addr 0x0005.
  -> R high on the cycle after the strobe is sampled; MDR_In=0x1234.
- Hold Mem_OE low for 10 cycles on a single read.
  -> exactly one R pulse.
  -> Raising the strobe, then lowering it again, starts a second access.
- With MEMIO_HEX_EN defined:
  - Write 0xBEEF to 0xFFFF -> HEX_OUT=0xBEEF.
  - Set SW=0x00A5 and read 0xFFFF -> MDR_In=0x00A5.
  - Without the macro, the same read -> 0x0000 and HEX_OUT stays 0x0000.
- Write 0xFFFF to addr 0x0400 (DEPTH=1024), then read 0x0000 and 0x0400.
  -> out-of-range write is dropped (0x0000 unchanged) and the read of 0x0400 returns 0x0000.
- Assert Reset during WAIT of a write of 0x7777 to 0x0010.
  -> next cycle R=0, MDR_In=0x0000, state=IDLE.
  -> A later read of 0x0010 returns its prior contents, not 0x7777.
